fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the single-issue RV32 core; sits directly upstream of the decode/control unit.
- Owns the PC. Issues word fetches to instruction memory over a request/response handshake, with at most one request outstanding.
- Presents each fetched instruction, its PC and PC+4 to decode with a valid/ready handshake.
- Accepts branch/jump redirects (the PCsrc path) and kills fetches on the wrong path.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset. Bits [1:0] must be 0.
- XLEN, 32: PC and instruction width. Only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  32  word address of the fetch, bits [1:0]=0
- imem_rsp_valid  in  1  response data valid, exactly one per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- redirect_valid  in  1  take redirect this cycle (PCsrc)
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0
- instr_valid  out  1  decode slot holds a valid instruction
- instr_ready  in  1  decode consumes the slot this cycle
- instr  out  32  instruction to decode/control
- instr_pc  out  32  PC of instr
- instr_pc_plus4  out  32  instr_pc+4 mod 2^32, used as the JAL/JALR link value

Behaviour:
- Reset (rst_n low, async): state=BOOT, pc=RESET_PC, drop=0, hold empty. imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr/instr_pc=0, instr_pc_plus4=4.
- Registers: pc (next fetch address); out slot {instr, instr_pc, valid}; hold buffer (one entry); drop flag.
- imem_req_valid=1 only in FETCH; imem_req_addr=pc.
- FSM transitions:
  - BOOT: always goes to FETCH on the next cycle. This guarantees no request is issued while reset is asserted.
  - FETCH: on imem_req_ready, latch inflight_pc=pc and go to WAIT. Hold is always empty in FETCH.
  - WAIT, response with drop=1: discard the data, clear drop, go to FETCH.
  - WAIT, response with drop=0 and the slot free (instr_valid=0 or instr_ready=1 this cycle): load the slot with the data and inflight_pc, set pc=inflight_pc+4, go to FETCH.
  - WAIT, response with drop=0 and the slot occupied (not consumed): store the data and inflight_pc into hold, set pc=inflight_pc+4, go to HOLD. No request is issued in HOLD.
  - HOLD: when instr_ready, move hold into the slot, clear hold, go to FETCH.
- Latency: request accepted at cycle N, response at N+k, instr_valid=1 at N+k+1. Sustained throughput is one instruction per k+1 cycles.
- Decode handshake: the slot is consumed when instr_valid and instr_ready are both high. It stays stable while instr_valid=1 and instr_ready=0. instr_valid drops after consumption unless a refill happens in the same cycle.
- Redirect (highest priority, any state except BOOT):
  - pc=redirect_target&~3; slot invalidated; hold cleared.
  - From FETCH without a handshake: stay in FETCH; the new address is driven next cycle.
  - From FETCH with imem_req_ready the same cycle: the old-address request is accepted. Go to WAIT with drop=1.
  - From WAIT without a response the same cycle: set drop=1, stay in WAIT.
  - From WAIT with a response the same cycle: discard it, drop=0, go to FETCH.
  - From HOLD: go to FETCH.
  - Redirect during BOOT is ignored.
- A redirect does not consume the slot; instr_ready in that cycle has no effect.
- Arithmetic: all PC math is 32-bit unsigned. 32'hFFFF_FFFC+4 wraps to 0 with no error.
- Reset asserted mid-operation: all state returns to reset values at once. Any in-flight response is the memory's responsibility; the memory must be reset by the same rst_n.
- No combinational path from imem_rsp_* to instr_* outputs. imem_req_valid depends only on state. instr_ready and redirect_valid are not required to be registered.

Test Plan:
- Sequential fetch: RESET_PC=0, memory k=1, always ready, instr_ready=1. Required: imem_req_addr 0,4,8,…; instr_pc 0,4,8 with the matching words; instr_pc_plus4=instr_pc+4; first instr_valid 3 cycles after rst_n rises.
- Decode backpressure: hold instr_ready=0 for 5 cycles after the first instruction. Required: the second response lands in HOLD; no third request is issued; instr/instr_pc stay stable. Release gives 0x0 then 0x4 on consecutive cycles with no loss or duplication.
- Redirect while WAIT: redirect to 0x100 with the request for 0x8 outstanding. Required: the 0x8 response is discarded (never instr_valid), the next request addr=0x100, instr_pc=0x100 next.
- Same-cycle redirect and response: redirect_valid=1 to 0x203 together with imem_rsp_valid. Required: data discarded, next request addr=0x200, no extra drop of the 0x200 response.
- Wrap: RESET_PC=32'hFFFF_FFFC. Required: instr_pc_plus4=0, second request addr=0x0.
- Async reset mid-WAIT: pull rst_n low. Required: imem_req_valid=0 and instr_valid=0 immediately, pc=RESET_PC, then the BOOT→FETCH sequence restarts cleanly.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the single-issue RV32 core.
// Owns the PC, issues one word fetch at a time over a req/rsp handshake,
// and hands {instr, pc, pc+4} to decode through a one-entry slot backed
// by a one-entry hold buffer. Redirects kill wrong-path fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] inflight_pc_r;
    logic            drop_r;
    logic [XLEN-1:0] hold_instr_r;
    logic [XLEN-1:0] hold_pc_r;
    logic            instr_valid_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] instr_pc_r;
    logic [XLEN-1:0] instr_pc_plus4_r;
    logic            req_valid_s;

    // Redirects are only honoured once the FSM has left BOOT.
    logic            redirect_s;
    logic            req_fire_s;
    logic            rsp_s;
    logic            slot_free_s;
    logic            rsp_keep_s;
    logic            load_rsp_s;
    logic            load_hold_s;
    logic            consume_s;
    logic [XLEN-1:0] redirect_pc_s;
    logic [XLEN-1:0] inflight_plus4_s;

    assign redirect_s       = redirect_valid && (state_r != ST_BOOT);
    assign req_fire_s       = (state_r == ST_FETCH) && imem_req_ready;
    assign rsp_s            = (state_r == ST_WAIT) && imem_rsp_valid;
    assign slot_free_s      = !instr_valid_r || instr_ready;
    assign rsp_keep_s       = rsp_s && !drop_r && !redirect_s;
    assign load_rsp_s       = rsp_keep_s && slot_free_s;
    assign load_hold_s      = (state_r == ST_HOLD) && instr_ready && !redirect_s;
    assign consume_s        = instr_valid_r && instr_ready && !redirect_s;
    assign redirect_pc_s    = redirect_target & 32'hFFFF_FFFC;
    assign inflight_plus4_s = inflight_pc_r + 32'd4;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a redirect never changes whether a request was
    // accepted, it only decides the fate of the returning data.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (!imem_rsp_valid) begin
                    state_nxt_s = ST_WAIT;
                end else if (redirect_s || drop_r || slot_free_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_s || instr_ready) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // FSM output decode: a request is offered only while in FETCH.
    always_comb begin
        req_valid_s = 1'b0;
        case (state_r)
            ST_FETCH: req_valid_s = 1'b1;
            default:  req_valid_s = 1'b0;
        endcase
    end

    // Next fetch address: redirect wins, otherwise advance past each kept response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_s) begin
            pc_r <= redirect_pc_s;
        end else if (rsp_keep_s) begin
            pc_r <= inflight_plus4_s;
        end
    end

    // Address of the outstanding request, captured on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_pc_r <= RESET_PC;
        end else if (req_fire_s) begin
            inflight_pc_r <= pc_r;
        end
    end

    // Drop flag: marks the outstanding response as wrong-path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_r <= 1'b0;
        end else if (redirect_s) begin
            // Only a request still in flight after this edge needs killing.
            drop_r <= req_fire_s || ((state_r == ST_WAIT) && !imem_rsp_valid);
        end else if (rsp_s) begin
            drop_r <= 1'b0;
        end
    end

    // Hold buffer: parks a response that arrives while decode is stalled.
    // Its valid bit is implied by the FSM being in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr_r <= 32'h0000_0000;
            hold_pc_r    <= 32'h0000_0000;
        end else if (rsp_keep_s && !slot_free_s) begin
            hold_instr_r <= imem_rsp_data;
            hold_pc_r    <= inflight_pc_r;
        end
    end

    // Decode slot: load from memory or hold, otherwise empty on consume/redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_r    <= 1'b0;
            instr_r          <= 32'h0000_0000;
            instr_pc_r       <= 32'h0000_0000;
            instr_pc_plus4_r <= 32'h0000_0004;
        end else if (redirect_s) begin
            instr_valid_r    <= 1'b0;
        end else if (load_rsp_s) begin
            instr_valid_r    <= 1'b1;
            instr_r          <= imem_rsp_data;
            instr_pc_r       <= inflight_pc_r;
            instr_pc_plus4_r <= inflight_plus4_s;
        end else if (load_hold_s) begin
            // In HOLD the PC was already advanced to hold_pc+4.
            instr_valid_r    <= 1'b1;
            instr_r          <= hold_instr_r;
            instr_pc_r       <= hold_pc_r;
            instr_pc_plus4_r <= pc_r;
        end else if (consume_s) begin
            instr_valid_r    <= 1'b0;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign instr_pc_plus4 = instr_pc_plus4_r;

endmodule
